// File: rtl/fpu_exec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FP execute controller that sits around the
// combinational FALU in the EX stage.
//   - FALU operation codes (4-bit Operation field)
//   - controller FSM state encoding
//   - bit positions of {exc, ovf, unf} inside 3-bit flag vectors
//   - default hold latencies and counter width
//   - isLegalOp(): helper to decide whether an op code maps to a FALU op
// ---------------------------------------------------------------------------
package fpu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;

  localparam int FLAG_EXC = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  localparam int LAT_ADD_DEF = 2;
  localparam int LAT_MUL_DEF = 3;
  localparam int LAT_DIV_DEF = 8;
  localparam int CNT_W_DEF   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Only the four arithmetic codes are driven into the FALU; anything else
  // would make it float its outputs.
  function automatic logic isLegalOp(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/fpu_exec_ctrl_if.sv
// ---------------------------------------------------------------------------
// fpu_exec_ctrl_if
// Bundles every non-clock signal of the FP execute controller.
//   Upstream (ID/EX) : flush, in_valid, in_ready, in_op, in_a, in_b, in_rd
//   FALU side        : falu_a, falu_b, falu_op, falu_result, falu_exc,
//                      falu_ovf, falu_unf
//   Downstream (MEM) : out_valid, out_ready, out_result, out_rd, out_flags
//   Status           : fflags_clr, fflags, busy
// Modports:
//   slave  - the controller itself
//   master - the surrounding pipeline / FALU (or a testbench)
// ---------------------------------------------------------------------------
interface fpu_exec_ctrl_if;

  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;

  logic [31:0] falu_a;
  logic [31:0] falu_b;
  logic [3:0]  falu_op;
  logic [31:0] falu_result;
  logic        falu_exc;
  logic        falu_ovf;
  logic        falu_unf;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [2:0]  out_flags;

  logic        fflags_clr;
  logic [2:0]  fflags;
  logic        busy;

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_rd,
    input  falu_result, falu_exc, falu_ovf, falu_unf,
    input  out_ready, fflags_clr,
    output in_ready, falu_a, falu_b, falu_op,
    output out_valid, out_result, out_rd, out_flags,
    output fflags, busy
  );

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_rd,
    output falu_result, falu_exc, falu_ovf, falu_unf,
    output out_ready, fflags_clr,
    input  in_ready, falu_a, falu_b, falu_op,
    input  out_valid, out_result, out_rd, out_flags,
    input  fflags, busy
  );

endinterface

// File: rtl/fpu_exec_ctrl_op_latency.sv
// ---------------------------------------------------------------------------
// fpu_op_latency
// Combinational map from a FALU op code to the counter preload used by the
// execute controller (hold latency minus one), plus an illegal-op flag.
// Ports:
//   i_op       in  4      op code from ID/EX
//   o_preload  out CNT_W  value loaded into the hold counter on accept
//   o_illegal  out 1      op code does not map to a FALU operation
// ---------------------------------------------------------------------------
module fpu_op_latency
  import fpu_pkg::*;
#(
  parameter int LAT_ADD = LAT_ADD_DEF,
  parameter int LAT_MUL = LAT_MUL_DEF,
  parameter int LAT_DIV = LAT_DIV_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic [3:0]       i_op,
  output logic [CNT_W-1:0] o_preload,
  output logic             o_illegal
);

  // The counter reaches zero on the last hold cycle, so it starts at LAT-1.
  always_comb begin
    o_preload = '0;
    o_illegal = !isLegalOp(i_op);
    case (i_op)
      OP_ADD,
      OP_SUB:  o_preload = CNT_W'(LAT_ADD - 1);
      OP_MUL:  o_preload = CNT_W'(LAT_MUL - 1);
      OP_DIV:  o_preload = CNT_W'(LAT_DIV - 1);
      default: o_preload = '0;
    endcase
  end

endmodule

// File: rtl/fpu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_exec_ctrl
// Multi-cycle issue/retire controller wrapped around the combinational FALU.
// Accepts one FP op at a time, holds the FALU operands stable for an
// op-dependent number of cycles, captures the result and flags, hands the
// result downstream over valid/ready and accumulates sticky fflags.
// Ports:
//   CLK    in  1  rising-edge clock
//   RESET  in  1  synchronous active-high reset
//   bus    slave modport of fpu_exec_ctrl_if (handshakes, FALU, flags)
// ---------------------------------------------------------------------------
module fpu_exec_ctrl
  import fpu_pkg::*;
#(
  parameter int LAT_ADD = LAT_ADD_DEF,
  parameter int LAT_MUL = LAT_MUL_DEF,
  parameter int LAT_DIV = LAT_DIV_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic             CLK,
  input logic             RESET,
  fpu_exec_ctrl_if.slave  bus
);

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic [31:0]      r_faluA;
  logic [31:0]      w_faluANext;
  logic [31:0]      r_faluB;
  logic [31:0]      w_faluBNext;
  logic [3:0]       r_faluOp;
  logic [3:0]       w_faluOpNext;
  logic [31:0]      r_result;
  logic [31:0]      w_resultNext;
  logic [4:0]       r_rd;
  logic [4:0]       w_rdNext;
  logic [2:0]       r_flags;
  logic [2:0]       w_flagsNext;
  logic [2:0]       r_fflags;
  logic [2:0]       w_fflagsNext;

  logic [CNT_W-1:0] w_preload;
  logic             w_illegal;
  logic             w_inReady;
  logic             w_accept;
  logic [2:0]       w_faluFlags;

  fpu_op_latency #(
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV),
    .CNT_W   (CNT_W)
  ) u_opLatency (
    .i_op      (bus.in_op),
    .o_preload (w_preload),
    .o_illegal (w_illegal)
  );

  // A flush in the same cycle blocks the accept, so flush always wins.
  assign w_inReady = (r_state == S_IDLE) && !bus.flush;
  assign w_accept  = bus.in_valid && w_inReady;

  always_comb begin
    w_faluFlags           = '0;
    w_faluFlags[FLAG_EXC] = bus.falu_exc;
    w_faluFlags[FLAG_OVF] = bus.falu_ovf;
    w_faluFlags[FLAG_UNF] = bus.falu_unf;
  end

  // Next-state and datapath update. The FALU outputs are only looked at on
  // the capture edge (EXEC with counter at zero); in every other state they
  // may be floating. The sticky-flag clear is applied before OR-ing in any
  // newly captured flags, so a clear and a capture together keep the new ones.
  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_faluANext  = r_faluA;
    w_faluBNext  = r_faluB;
    w_faluOpNext = r_faluOp;
    w_resultNext = r_result;
    w_rdNext     = r_rd;
    w_flagsNext  = r_flags;
    w_fflagsNext = bus.fflags_clr ? 3'b000 : r_fflags;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_rdNext = bus.in_rd;
          if (w_illegal) begin
            w_resultNext           = '0;
            w_flagsNext            = '0;
            w_flagsNext[FLAG_EXC]  = 1'b1;
            w_fflagsNext[FLAG_EXC] = 1'b1;
            w_stateNext            = S_DONE;
          end else begin
            w_faluANext  = bus.in_a;
            w_faluBNext  = bus.in_b;
            w_faluOpNext = bus.in_op;
            w_cntNext    = w_preload;
            w_stateNext  = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        if (bus.flush) begin
          w_cntNext   = '0;
          w_stateNext = S_IDLE;
        end else if (r_cnt == '0) begin
          w_resultNext = bus.falu_result;
          w_flagsNext  = w_faluFlags;
          w_fflagsNext = w_fflagsNext | w_faluFlags;
          w_stateNext  = S_DONE;
        end else begin
          w_cntNext = r_cnt - CNT_W'(1);
        end
      end

      S_DONE: begin
        if (bus.flush || bus.out_ready) begin
          w_stateNext = S_IDLE;
        end
      end

      default: begin
        w_cntNext   = '0;
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; a reset mid-op
  // simply discards whatever was in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_faluA  <= '0;
      r_faluB  <= '0;
      r_faluOp <= '0;
      r_result <= '0;
      r_rd     <= '0;
      r_flags  <= '0;
      r_fflags <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_faluA  <= w_faluANext;
      r_faluB  <= w_faluBNext;
      r_faluOp <= w_faluOpNext;
      r_result <= w_resultNext;
      r_rd     <= w_rdNext;
      r_flags  <= w_flagsNext;
      r_fflags <= w_fflagsNext;
    end
  end

  assign bus.in_ready   = w_inReady;
  assign bus.falu_a     = r_faluA;
  assign bus.falu_b     = r_faluB;
  assign bus.falu_op    = r_faluOp;
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.out_result = r_result;
  assign bus.out_rd     = r_rd;
  assign bus.out_flags  = r_flags;
  assign bus.fflags     = r_fflags;
  assign bus.busy       = (r_state != S_IDLE);

endmodule
